// File: rtl/dp_types_pkg.sv
// Shared datapath types: register address width, hazard sequencer state and
// the bundle of pipeline control strobes driven by the hazard controller.
package dp_types_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] regaddr_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic imemREN;
  } hazard_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the ID/EX load writes a register that the
// IF/ID instruction reads. Writes to $zero never stall.
module load_use_detect
  import dp_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regaddr_t idex_rt,
  input  regaddr_t ifid_rs,
  input  regaddr_t ifid_rt,
  output logic     stall
);

  assign stall = idex_dREN && (idex_rt != '0) &&
                 ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: latch enables/flushes, PC enable, fetch request
// and the halt drain. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module pipeline_hazard_ctrl
  import dp_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       idex_dREN,
  input  logic [4:0] idex_rt,
  input  logic       exmem_dREN,
  input  logic       exmem_dWEN,
  input  logic       exmem_redirect,
  input  logic       exmem_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       imemREN,
  output logic       halt,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic [1:0] state
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             halt_q, halt_d;

  logic         load_use;
  logic         dreq_pending;
  logic         drain_last;
  logic         apply_run_rules;
  logic         redirect_flush;
  hazard_ctrl_t ctrl;

  load_use_detect u_load_use (
    .idex_dREN (idex_dREN),
    .idex_rt   (idex_rt),
    .ifid_rs   (ifid_rs),
    .ifid_rt   (ifid_rt),
    .stall     (load_use)
  );

  assign dreq_pending = (exmem_dREN || exmem_dWEN) && !dhit;
  assign drain_last   = (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1));

  // Rules 3..6 run in RUN once halt and pending data are ruled out, and in
  // the DWAIT cycle where the data access completes.
  assign apply_run_rules = ((state_q == RUN) && !exmem_halt && !dreq_pending) ||
                           ((state_q == DWAIT) && dhit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_q      <= halt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halt_d      = halt_q;
    case (state_q)
      RUN: begin
        if (exmem_halt)        state_d = DRAIN;
        else if (dreq_pending) state_d = DWAIT;
      end
      DWAIT: begin
        if (dhit) state_d = RUN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_last) begin
          halt_d  = 1'b1;
          state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  // A flushed latch has its enable held low; the flush alone defines its load.
  always_comb begin
    ctrl           = '0;
    redirect_flush = 1'b0;
    case (state_q)
      RUN: begin
        ctrl.imemREN = 1'b1;
        if (exmem_halt) begin
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
          ctrl.memwb_en    = 1'b1;
        end
      end
      DRAIN: begin
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
        ctrl.memwb_en    = 1'b1;
      end
      default: ;
    endcase

    if (apply_run_rules) begin
      if (exmem_redirect) begin
        redirect_flush   = 1'b1;
        ctrl.pc_en       = 1'b1;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
        ctrl.memwb_en    = 1'b1;
      end else if (load_use) begin
        ctrl.idex_flush = 1'b1;
        ctrl.exmem_en   = 1'b1;
        ctrl.memwb_en   = 1'b1;
      end else if (!ihit) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_en    = 1'b1;
        ctrl.exmem_en   = 1'b1;
        ctrl.memwb_en   = 1'b1;
      end else begin
        ctrl.pc_en    = 1'b1;
        ctrl.ifid_en  = 1'b1;
        ctrl.idex_en  = 1'b1;
        ctrl.exmem_en = 1'b1;
        ctrl.memwb_en = 1'b1;
      end
    end
  end

  // Reset forces every strobe quiet even before the first clock edge.
  assign pc_en       = ctrl.pc_en       && !RST;
  assign ifid_en     = ctrl.ifid_en     && !RST;
  assign idex_en     = ctrl.idex_en     && !RST;
  assign exmem_en    = ctrl.exmem_en    && !RST;
  assign memwb_en    = ctrl.memwb_en    && !RST;
  assign ifid_flush  = ctrl.ifid_flush  && !RST;
  assign idex_flush  = ctrl.idex_flush  && !RST;
  assign exmem_flush = ctrl.exmem_flush && !RST;
  assign imemREN     = ctrl.imemREN     && !RST;
  assign halt        = halt_q;
  assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        count_stall;

  assign count_stall = !ctrl.pc_en && ((state_q == RUN) || (state_q == DWAIT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (count_stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
